mole_round_ctrl: RTL and testbench

MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

---
 rtl/mole_round_ctrl_pkg.sv | 34 +++
 rtl/mole_round_ctrl_interval_counter.sv | 43 ++++
 rtl/mole_round_ctrl.sv | 151 +++++++++++++++
 tb/tb_mole_round_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_round_ctrl_pkg.sv
// Shared constants for the whack-a-mole round controller: FSM encoding, LFSR seed/taps,
// speedup step and the timer tick rate.
// Latency: n/a (types, constants, pure functions only).
// Backpressure: n/a.
package mole_round_ctrl_pkg;

  // Clock cycles per 1 Hz timer tick. Set to the real clock rate for silicon builds.
  localparam int CLK_FREQ = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_UP     = 3'd2,
    ST_RESULT = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left: feedback from bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Cumulative hits between interval reductions (power of two).
  localparam int SPEEDUP_HITS = 4;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

  // Nudge the candidate hole by one (mod 8) when it repeats the previous mole.
  function automatic logic [2:0] pick_pos(input logic [2:0] cand, input logic [2:0] prev);
    return (cand == prev) ? cand + 3'd1 : cand;
  endfunction

endpackage

// File: rtl/mole_round_ctrl_interval_counter.sv
// Seconds timer: a prescaler makes a tick every CLK_FREQ cycles; count moves once per tick.
// Latency: timeout is combinational in the cycle of the (interval+1)-th tick after reset release.
// Backpressure: none; free-running while rst_n is high.
//
// Ports: clk, rst_n (sync, active-low, loads the interval), dir (0 = count down from
// interval to 0, 1 = count up from 0 to interval), interval, count, timeout.
module interval_counter #(
  parameter int CLK_FREQ = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dir,
  input  logic [CNT_W-1:0] interval,
  output logic [CNT_W-1:0] count,
  output logic             timeout
);

  localparam int             PRE_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             at_end;

  assign tick    = (pre_cnt == PRE_LAST);
  assign at_end  = dir ? (count == interval) : (count == '0);
  // Firing on the tick that finds count already at its end gives (interval+1) ticks total.
  assign timeout = tick && at_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      count   <= dir ? '0 : interval;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick && !at_end) begin
        count <= dir ? count + 1'b1 : count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: shows a mole at a pseudo-random hole, scores hits, counts timeouts.
// Latency: hit in cycle N -> score updated, mole_vld=0 in N+1; next mole shown in N+3.
// Backpressure: none; start is a level sampled only in IDLE and OVER, hits only in UP.
//
// Ports: clk, rst_n (sync, active-low), start, hit_vld, hit_pos[2:0] in;
//        mole_vld, mole_pos[2:0], score[SCORE_W-1:0], misses[2:0], time_left[2:0], game_over out.
// Build option: define SPEEDUP_EN to shorten the mole-up interval every 4th hit (floor 1 s).
module mole_round_ctrl #(
  parameter int INTERVAL_INIT = 5,
  parameter int MAX_MISSES    = 3,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hit_vld,
  input  logic [2:0]         hit_pos,
  output logic               mole_vld,
  output logic [2:0]         mole_pos,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         misses,
  output logic [2:0]         time_left,
  output logic               game_over
);
  import mole_round_ctrl_pkg::*;

  localparam logic [2:0] INTERVAL_RST = 3'(INTERVAL_INIT);
  localparam logic [2:0] MISS_LIMIT   = 3'(MAX_MISSES);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] lfsr;
  logic [2:0] interval_cur;
  logic [2:0] timer_count;
  logic       timer_rst_n;
  logic       timeout;
  logic       hit_match;

  assign hit_match   = hit_vld && (hit_pos == mole_pos);
  // ARM restarts the timer so every mole gets a full interval.
  assign timer_rst_n = rst_n & ~(state == ST_ARM);

  interval_counter #(
    .CLK_FREQ (CLK_FREQ),
    .CNT_W    (3)
  ) u_timer (
    .clk      (clk),
    .rst_n    (timer_rst_n),
    .dir      (1'b0),
    .interval (interval_cur),
    .count    (timer_count),
    .timeout  (timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mole_vld  = 1'b0;
    game_over = 1'b0;
    time_left = 3'd0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        state_nxt = ST_UP;
      end
      ST_UP: begin
        mole_vld  = 1'b1;
        time_left = timer_count;
        if (hit_match || timeout) state_nxt = ST_RESULT;
      end
      ST_RESULT: begin
        // misses was already updated on the edge into RESULT.
        state_nxt = (misses == MISS_LIMIT) ? ST_OVER : ST_ARM;
      end
      ST_OVER: begin
        game_over = 1'b1;
        if (start) state_nxt = ST_ARM;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Score/misses update on the edge that leaves UP so RESULT already shows the outcome.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr     <= LFSR_SEED;
      mole_pos <= '0;
      score    <= '0;
      misses   <= '0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      case (state)
        ST_ARM: begin
          mole_pos <= pick_pos(lfsr[2:0], mole_pos);
        end
        ST_UP: begin
          // A matching hit wins over a simultaneous timeout.
          if (hit_match) begin
            if (score != '1) score <= score + 1'b1;
          end else if (timeout) begin
            misses <= misses + 3'd1;
          end
        end
        ST_OVER: begin
          if (start) begin
            score  <= '0;
            misses <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPEEDUP_EN
  localparam int SPD_BITS = $clog2(SPEEDUP_HITS);

  logic last_hit;

  // last_hit remembers whether the round that just closed was a hit; a saturated
  // score never wraps its low bits, so no further speedups happen once pinned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_hit     <= 1'b0;
      interval_cur <= INTERVAL_RST;
    end else begin
      if (state == ST_UP) last_hit <= hit_match;
      if (state == ST_RESULT && last_hit && score[SPD_BITS-1:0] == '0 &&
          interval_cur > 3'd1) begin
        interval_cur <= interval_cur - 3'd1;
      end else if (state == ST_OVER && start) begin
        interval_cur <= INTERVAL_RST;
      end
    end
  end
`else
  assign interval_cur = INTERVAL_RST;
`endif

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl: table of rounds with expected score/misses, a score/miss
// scoreboard, an independent LFSR model for hole prediction, plus hand-written corner sequences.
module tb_mole_round_ctrl;

  localparam int CLK_FREQ_SIM = 4;
  localparam int INIT_IV      = 2;
  localparam int MAX_M        = 3;
  localparam int SW           = 8;

  typedef enum int {A_HIT, A_WRONG_HIT, A_MISS, A_HIT_AT_TO} act_t;
  typedef struct {
    act_t act;
    int   exp_score;
    int   exp_misses;
    bit   exp_over;
  } vec_t;
  typedef struct {
    int score;
    int misses;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          hit_vld = 1'b0;
  logic [2:0]    hit_pos = 3'd0;
  logic          mole_vld;
  logic [2:0]    mole_pos;
  logic [SW-1:0] score;
  logic [2:0]    misses;
  logic [2:0]    time_left;
  logic          game_over;

  logic          z_mole_vld;
  logic [2:0]    z_mole_pos;
  logic [SW-1:0] z_score;
  logic [2:0]    z_misses;
  logic [2:0]    z_time_left;
  logic          z_game_over;

  always #5 clk = ~clk;

  mole_round_ctrl #(.INTERVAL_INIT(INIT_IV), .MAX_MISSES(MAX_M), .SCORE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit_vld(hit_vld), .hit_pos(hit_pos),
    .mole_vld(mole_vld), .mole_pos(mole_pos), .score(score), .misses(misses),
    .time_left(time_left), .game_over(game_over)
  );

  // Second instance with a zero interval; never hit, only its first round is examined.
  mole_round_ctrl #(.INTERVAL_INIT(0), .MAX_MISSES(MAX_M), .SCORE_W(SW)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .hit_vld(1'b0), .hit_pos(3'd0),
    .mole_vld(z_mole_vld), .mole_pos(z_mole_pos), .score(z_score), .misses(z_misses),
    .time_left(z_time_left), .game_over(z_game_over)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  sb_t        sb_q[$];
  vec_t       vecs[11];
  logic [7:0] m_lfsr;
  logic [7:0] m_lfsr_d1;
  logic [2:0] prev_pos = 3'd0;
  logic [2:0] cur_pos  = 3'd0;
  int         exp_iv   = INIT_IV;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, one step per clock.
  always @(posedge clk) begin
    m_lfsr_d1 <= m_lfsr;
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called in the first UP cycle: predicts the hole from the ARM-cycle LFSR value.
  task automatic enter_up(input string tag);
    logic [2:0] cand;
    logic [2:0] exp_pos;
    cand    = m_lfsr_d1[2:0];
    exp_pos = (cand == prev_pos) ? cand + 3'd1 : cand;
    check({tag, "_mole_vld"}, mole_vld, 1);
    check({tag, "_mole_pos"}, mole_pos, exp_pos);
    check({tag, "_pos_changed"}, (mole_pos != prev_pos), 1);
    check({tag, "_time_left"}, time_left, exp_iv);
    prev_pos = exp_pos;
    cur_pos  = exp_pos;
  endtask

  task automatic start_game();
    exp_iv = INIT_IV;
    start  = 1'b1;
    step();
    start  = 1'b0;
    check("arm_mole_vld", mole_vld, 0);
    check("arm_score", score, 0);
    check("arm_misses", misses, 0);
    check("arm_time_left", time_left, 0);
    check("arm_game_over", game_over, 0);
    step();
    enter_up("start");
  endtask

  // Plays one round from the first UP cycle; ends in the next UP cycle 1 or in OVER.
  task automatic run_round(input act_t act, input int es, input int em, input bit eover);
    int  len;
    int  cnt;
    bit  is_hit;
    sb_t e;
    len    = (exp_iv + 1) * CLK_FREQ_SIM;
    cnt    = 0;
    is_hit = (act != A_MISS);
    sb_q.push_back('{score: es, misses: em});
    case (act)
      A_HIT: begin
        hit_vld = 1'b1; hit_pos = cur_pos; step(); hit_vld = 1'b0;
      end
      A_WRONG_HIT: begin
        hit_vld = 1'b1; hit_pos = cur_pos ^ 3'd4; step(); hit_vld = 1'b0;
        check("wrong_hole_still_up", mole_vld, 1);
        check("wrong_hole_score", score, es - 1);
        hit_vld = 1'b1; hit_pos = cur_pos; step(); hit_vld = 1'b0;
      end
      A_MISS: begin
        while (mole_vld === 1'b1 && cnt < 100) begin
          step();
          cnt++;
          if (cnt == CLK_FREQ_SIM) check("time_left_after_tick", time_left, exp_iv - 1);
        end
        check("up_cycles_to_timeout", cnt, len);
      end
      A_HIT_AT_TO: begin
        step(len - 1);
        check("up_in_timeout_cycle", mole_vld, 1);
        check("time_left_at_timeout", time_left, 0);
        hit_vld = 1'b1; hit_pos = cur_pos; step(); hit_vld = 1'b0;
      end
      default: ;
    endcase
    // RESULT cycle
    check("result_mole_vld", mole_vld, 0);
    check("result_time_left", time_left, 0);
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("result_score", score, e.score);
      check("result_misses", misses, e.misses);
    end
`ifdef SPEEDUP_EN
    if (is_hit && (es % 4) == 0 && exp_iv > 1) exp_iv--;
`endif
    step();
    if (eover) begin
      check("over_game_over", game_over, 1);
      check("over_mole_vld", mole_vld, 0);
    end else begin
      check("rearm_mole_vld", mole_vld, 0);
      check("rearm_game_over", game_over, 0);
      step();
      enter_up(is_hit ? "after_hit" : "after_miss");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{A_HIT,       1, 0, 1'b0};
    vecs[1]  = '{A_WRONG_HIT, 2, 0, 1'b0};
    vecs[2]  = '{A_MISS,      2, 1, 1'b0};
    vecs[3]  = '{A_HIT_AT_TO, 3, 1, 1'b0};
    vecs[4]  = '{A_HIT,       4, 1, 1'b0};
    vecs[5]  = '{A_MISS,      4, 2, 1'b0};
    vecs[6]  = '{A_HIT,       5, 2, 1'b0};
    vecs[7]  = '{A_HIT,       6, 2, 1'b0};
    vecs[8]  = '{A_HIT,       7, 2, 1'b0};
    vecs[9]  = '{A_HIT,       8, 2, 1'b0};
    vecs[10] = '{A_MISS,      8, 3, 1'b1};

    // Reset values
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    check("rst_mole_vld", mole_vld, 0);
    check("rst_mole_pos", mole_pos, 0);
    check("rst_score", score, 0);
    check("rst_misses", misses, 0);
    check("rst_game_over", game_over, 0);
    check("rst_time_left", time_left, 0);
    step(3);
    check("idle_no_start", mole_vld, 0);

    // Zero interval: one tick (CLK_FREQ cycles) in UP
    start_game();
    check("iv0_time_left", z_time_left, 0);
    check("iv0_up", z_mole_vld, 1);
    step(CLK_FREQ_SIM - 1);
    check("iv0_still_up", z_mole_vld, 1);
    step();
    check("iv0_timed_out", z_mole_vld, 0);
    check("iv0_miss", z_misses, 1);

    // Reset mid-UP of the main instance (score 0 here)
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    prev_pos = 3'd0;
    check("rst1_mole_vld", mole_vld, 0);
    check("rst1_time_left", time_left, 0);

    // Table-driven game
    start_game();
    for (int i = 0; i < 11; i++) begin
      run_round(vecs[i].act, vecs[i].exp_score, vecs[i].exp_misses, vecs[i].exp_over);
    end
    step(2);
    check("over_holds", game_over, 1);
    check("over_time_left", time_left, 0);

    // Restart from OVER; start held through a full round must be ignored
    start_game();
    start = 1'b1;
    step();
    check("start_ignored_in_up", mole_vld, 1);
    run_round(A_HIT, 1, 0, 1'b0);
    start = 1'b0;

    // Reset mid-UP with a nonzero score
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    prev_pos = 3'd0;
    check("rst2_mole_vld", mole_vld, 0);
    check("rst2_mole_pos", mole_pos, 0);
    check("rst2_score", score, 0);
    check("rst2_misses", misses, 0);
    check("rst2_game_over", game_over, 0);
    check("rst2_time_left", time_left, 0);
    step();
    check("rst2_idle", mole_vld, 0);

    // Three straight timeouts end the game
    start_game();
    for (int m = 1; m <= MAX_M; m++) begin
      run_round(A_MISS, 0, m, (m == MAX_M));
    end

    // Score saturation at all-ones
    start_game();
    for (int i = 1; i <= 257; i++) begin
      run_round(A_HIT, (i > 255) ? 255 : i, 0, 1'b0);
    end
    check("score_saturated", score, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
